// File: rtl/writeback.sv
// Final stage: commits regfile writes (1-cycle latency), counts retirements/branches, never stalls exec.
// On exception: flush for FLUSH_CYCLES then redirect to TRAP_VECTOR; WB_HALT_ON_TRAP_EN halts instead.
module writeback #(
   parameter int              XLEN         = 32,
   parameter int              ALEN         = 32,
   parameter logic [ALEN-1:0] TRAP_VECTOR  = 'h100,
   parameter int              FLUSH_CYCLES = 3,
   parameter int              CNT_W        = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prev_stalled,
   input  logic             exec_exception,
   input  logic             exec_is_branch,
   input  logic             exec_is_reg_write,
   input  logic [4:0]       exec_reg_write_sel,
   input  logic [XLEN-1:0]  exec_result,
   input  logic [ALEN-1:0]  exec_branch_target,
   input  logic [ALEN-1:0]  exec_instruction_next_addr,
   output logic             reg_write_en,
   output logic [4:0]       reg_write_sel,
   output logic [XLEN-1:0]  reg_write_data,
   output logic             flush,
   output logic             redirect_valid,
   output logic [ALEN-1:0]  redirect_addr,
   output logic [ALEN-1:0]  trap_next_addr,
   output logic             halted,
   output logic [CNT_W-1:0] retired_count,
   output logic [CNT_W-1:0] branch_count
);

   typedef enum logic [1:0] {
      RUN,
      TRAP_FLUSH,
      TRAP_REDIRECT
`ifdef WB_HALT_ON_TRAP_EN
      , HALT
`endif
   } state_t;

   state_t     state, state_next;
   logic [3:0] flush_cnt, flush_cnt_next;
   logic       accept, commit, do_write;
   logic       unused_target;

   // The branch target is informational only; the branch itself is what gets counted.
   assign unused_target = ^exec_branch_target;

   assign accept   = !prev_stalled && (state == RUN);
   assign commit   = accept && !exec_exception;
   assign do_write = commit && exec_is_reg_write && (exec_reg_write_sel != 5'd0);

   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
`ifdef WB_HALT_ON_TRAP_EN
      halted         = 1'b0;
`endif
      case (state)
         RUN: begin
            if (accept && exec_exception) begin
               state_next     = TRAP_FLUSH;
               flush_cnt_next = 4'(FLUSH_CYCLES);
            end
         end
         TRAP_FLUSH: begin
            flush          = 1'b1;
            flush_cnt_next = flush_cnt - 4'd1;
            if (flush_cnt == 4'd1) begin
`ifdef WB_HALT_ON_TRAP_EN
               state_next = HALT;
`else
               state_next = TRAP_REDIRECT;
`endif
            end
         end
         TRAP_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_addr  = TRAP_VECTOR;
            state_next     = RUN;
         end
`ifdef WB_HALT_ON_TRAP_EN
         HALT: begin
            flush  = 1'b1;
            halted = 1'b1;
         end
`endif
         default: state_next = RUN;
      endcase
   end

`ifndef WB_HALT_ON_TRAP_EN
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= RUN;
         flush_cnt      <= 4'd0;
         trap_next_addr <= '0;
         reg_write_en   <= 1'b0;
         reg_write_sel  <= 5'd0;
         reg_write_data <= '0;
         retired_count  <= '0;
         branch_count   <= '0;
      end else begin
         state          <= state_next;
         flush_cnt      <= flush_cnt_next;
         reg_write_en   <= do_write;
         reg_write_sel  <= do_write ? exec_reg_write_sel : 5'd0;
         reg_write_data <= do_write ? exec_result : '0;
         if (accept && exec_exception)
            trap_next_addr <= exec_instruction_next_addr;
         if (commit) begin
            retired_count <= retired_count + CNT_W'(1);
            if (exec_is_branch)
               branch_count <= branch_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: write/redirect scoreboards drained by a negedge monitor, plus directed counter/trap checks.
module tb_writeback;
   localparam int XLEN  = 32;
   localparam int ALEN  = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             prev_stalled;
   logic             exec_exception;
   logic             exec_is_branch;
   logic             exec_is_reg_write;
   logic [4:0]       exec_reg_write_sel;
   logic [XLEN-1:0]  exec_result;
   logic [ALEN-1:0]  exec_branch_target;
   logic [ALEN-1:0]  exec_instruction_next_addr;
   logic             reg_write_en;
   logic [4:0]       reg_write_sel;
   logic [XLEN-1:0]  reg_write_data;
   logic             flush;
   logic             redirect_valid;
   logic [ALEN-1:0]  redirect_addr;
   logic [ALEN-1:0]  trap_next_addr;
   logic             halted;
   logic [CNT_W-1:0] retired_count;
   logic [CNT_W-1:0] branch_count;

   always #5 clk = ~clk;

   writeback #(.XLEN(XLEN), .ALEN(ALEN), .TRAP_VECTOR('h100), .FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .prev_stalled(prev_stalled), .exec_exception(exec_exception),
      .exec_is_branch(exec_is_branch), .exec_is_reg_write(exec_is_reg_write),
      .exec_reg_write_sel(exec_reg_write_sel), .exec_result(exec_result),
      .exec_branch_target(exec_branch_target),
      .exec_instruction_next_addr(exec_instruction_next_addr),
      .reg_write_en(reg_write_en), .reg_write_sel(reg_write_sel), .reg_write_data(reg_write_data),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .trap_next_addr(trap_next_addr), .halted(halted),
      .retired_count(retired_count), .branch_count(branch_count)
   );

   typedef struct {
      logic [4:0]      sel;
      logic [XLEN-1:0] data;
   } wr_t;

   wr_t             wq[$];
   logic [ALEN-1:0] rq[$];
   int              checks = 0;
   int              errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic stalled, input logic exc, input logic br, input logic wr,
                      input logic [4:0] sel, input logic [XLEN-1:0] res, input logic [ALEN-1:0] nxt);
      prev_stalled               = stalled;
      exec_exception             = exc;
      exec_is_branch             = br;
      exec_is_reg_write          = wr;
      exec_reg_write_sel         = sel;
      exec_result                = res;
      exec_branch_target         = res ^ 32'h0000_0f0f;
      exec_instruction_next_addr = nxt;
   endtask

   task automatic push_wr(input logic [4:0] sel, input logic [XLEN-1:0] data);
      wr_t e;
      e.sel  = sel;
      e.data = data;
      wq.push_back(e);
   endtask

   // Monitor: every strobe must match the oldest expected write/redirect; idle cycles must be zero.
   always @(negedge clk) begin
      if (rst) begin
         if (reg_write_en) begin
            if (wq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got sel=%0d data='h%0h expected no write", reg_write_sel, reg_write_data);
            end else begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_sel", 64'(reg_write_sel), 64'(e.sel));
               chk("wr_data", 64'(reg_write_data), 64'(e.data));
            end
         end else begin
            chk("wr_idle_zero", {27'd0, reg_write_sel, reg_write_data}, 64'd0);
         end
         if (redirect_valid) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_redirect: got addr='h%0h expected no redirect", redirect_addr);
            end else begin
               chk("redirect_addr", 64'(redirect_addr), 64'(rq.pop_front()));
            end
         end else begin
            chk("redirect_idle_zero", 64'(redirect_addr), 64'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
      #3;
      chk("rst_wr_en", 64'(reg_write_en), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_redirect", 64'(redirect_valid), 64'd0);
      chk("rst_trap_addr", 64'(trap_next_addr), 64'd0);
      chk("rst_retired", 64'(retired_count), 64'd0);
      chk("rst_branch", 64'(branch_count), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      step();
      step();
      rst = 1'b1;
      step();

      // Basic write, one-cycle pulse.
      drv(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD, 32'h4);
      push_wr(5'd5, 32'hDEAD);
      step();
      chk("t1_wr_en", 64'(reg_write_en), 64'd1);
      chk("t1_retired", 64'(retired_count), 64'd1);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
      step();
      chk("t1_pulse_end", 64'(reg_write_en), 64'd0);

      // x0 write is suppressed but still retires.
      drv(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd7, 32'h8);
      step();
      chk("t2_x0_wr_en", 64'(reg_write_en), 64'd0);
      chk("t2_retired", 64'(retired_count), 64'd2);

      drv(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h55, 32'hC);
      push_wr(5'd3, 32'h55);
      step();
      chk("t3_retired", 64'(retired_count), 64'd3);
      chk("t3_branch", 64'(branch_count), 64'd1);

      drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99, 32'h10);
      step();
      chk("t4_nowrite_en", 64'(reg_write_en), 64'd0);
      chk("t4_retired", 64'(retired_count), 64'd4);

      // Stalled cycles carry garbage that must be ignored.
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, i[0], 1'b1, 1'b1, 5'(i + 1), $urandom, $urandom);
         step();
      end
      chk("t5_retired", 64'(retired_count), 64'd4);
      chk("t5_branch", 64'(branch_count), 64'd1);
      chk("t5_flush", 64'(flush), 64'd0);

      // Exception: no commit; flush +1..+3; stale exceptions held throughout.
      drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'hBAD, 32'h1004);
`ifndef WB_HALT_ON_TRAP_EN
      rq.push_back(32'h100);
`endif
      step();
      chk("trap_next_addr", 64'(trap_next_addr), 64'h1004);
      chk("trap_flush_p1", 64'(flush), 64'd1);
      chk("trap_retired", 64'(retired_count), 64'd4);
      chk("trap_branch", 64'(branch_count), 64'd1);
      drv(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h1, 32'h2222);
`ifndef WB_HALT_ON_TRAP_EN
      step();
      chk("trap_flush_p2", 64'(flush), 64'd1);
      step();
      chk("trap_flush_p3", 64'(flush), 64'd1);
      step();
      chk("trap_flush_p4", 64'(flush), 64'd0);
      chk("trap_redirect_p4", 64'(redirect_valid), 64'd1);
      chk("trap_addr_kept", 64'(trap_next_addr), 64'h1004);
      step();
      drv(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hAB, 32'h14);
      push_wr(5'd7, 32'hAB);
      step();
      chk("resume_retired", 64'(retired_count), 64'd5);
      chk("resume_flush", 64'(flush), 64'd0);
      chk("resume_redirect", 64'(redirect_valid), 64'd0);

      // Reset in the middle of a flush window.
      drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, '0, 32'h2000);
      step();
      chk("rtrap_flush", 64'(flush), 64'd1);
      chk("rtrap_addr", 64'(trap_next_addr), 64'h2000);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
      #3;
      rst = 1'b0;
      #1;
      chk("rtrap_async_flush", 64'(flush), 64'd0);
      chk("rtrap_async_redirect", 64'(redirect_valid), 64'd0);
      chk("rtrap_async_addr", 64'(trap_next_addr), 64'd0);
      chk("rtrap_async_retired", 64'(retired_count), 64'd0);
`else
      for (int i = 0; i < 20; i++) begin
         step();
         chk("halt_flush", 64'(flush), 64'd1);
         chk("halt_halted", 64'(halted), 64'd1);
      end
      drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
      #3;
      rst = 1'b0;
      #1;
      chk("halt_async_halted", 64'(halted), 64'd0);
      chk("halt_async_flush", 64'(flush), 64'd0);
      chk("halt_async_addr", 64'(trap_next_addr), 64'd0);
`endif
      step();
      rst = 1'b1;
      step();

      // Counter wrap with 4-bit counters.
      for (int i = 0; i < 16; i++) begin
         drv(1'b0, 1'b0, 1'b0, 1'b1, 5'(i + 1), 32'(i * 3 + 1), 32'(i * 4));
         push_wr(5'(i + 1), 32'(i * 3 + 1));
         step();
         if (i == 14) chk("wrap_retired_15", 64'(retired_count), 64'd15);
      end
      drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
      chk("wrap_retired_0", 64'(retired_count), 64'd0);
      chk("wrap_branch_0", 64'(branch_count), 64'd0);
      step();
      step();
      chk("wq_drained", 64'(wq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
